pc_gen: RTL and testbench

//  Parametrised fetch-PC generator; next generation of the core's program counter.

---
 rtl/pc_gen.sv | 236 +++++++++++++++++++++++
 tb/tb_pc_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen : fetch program-counter generator with a circular return address stack
//
// Produces the fetch address for instruction memory over a valid/ready
// handshake. The PC advances by 2 or 4 bytes on each accepted request. It can
// also be loaded, in this priority order, from a trap vector, from a
// return-stack pop or redirect target, or from a redirect target alone. Every
// load inserts a single bubble cycle in which no request is issued.
//
// Parameters
//   XLEN       address width; PC arithmetic wraps modulo 2^XLEN
//   RESET_VEC  PC value loaded by reset
//   RAS_DEPTH  return-address-stack entries (power of 2, >= 2)
//   C_EXT      1: 2-byte steps/alignment legal, 0: 4-byte only
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   fetch_valid  out  fetch_pc is a valid request (registered)
//   fetch_ready  in   imem accepts the request this cycle
//   fetch_pc     out  current fetch address (registered)
//   pc_next      out  fetch_pc + step (combinational)
//   step_c       in   current instruction is compressed (step 2)
//   trap_en      in   load trap_vec (highest priority)
//   trap_vec     in   trap target
//   redirect_en  in   load redirect_pc
//   redirect_pc  in   redirect target
//   call_en      in   push pc_next on the RAS (with redirect_en or ret_en)
//   ret_en       in   pop the RAS and load the popped address
//   ras_empty    out  RAS holds no entries (registered)
//   ras_full     out  RAS holds RAS_DEPTH entries (registered)
//   misalign     out  one-cycle pulse: last loaded target was misaligned
// -----------------------------------------------------------------------------
module pc_gen #(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_VEC = 32'h8000_0000,
  parameter int                RAS_DEPTH = 4,
  parameter int                C_EXT     = 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] pc_next,
  input  logic            step_c,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            call_en,
  input  logic            ret_en,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            misalign
);

  localparam logic [1:0] BOOT   = 2'b00;
  localparam logic [1:0] RUN    = 2'b01;
  localparam logic [1:0] BUBBLE = 2'b10;

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  // Low address bits that must be zero in a legal target.
  localparam logic [XLEN-1:0] ALIGN_MASK = (C_EXT != 0) ?
                                           {{(XLEN-1){1'b1}}, 1'b0} :
                                           {{(XLEN-2){1'b1}}, 2'b00};

  // True when the address has any bit set below the legal alignment.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return |(addr & ~ALIGN_MASK);
  endfunction

  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_nxt_s;
  logic [XLEN-1:0] pc_next_s;
  logic [XLEN-1:0] step_s;
  logic [XLEN-1:0] target_s;
  logic            load_s;
  logic            fetch_valid_r;
  logic            misalign_r;
  logic            misalign_nxt_s;

  logic [XLEN-1:0] ras_mem_r [RAS_DEPTH];
  logic [PW-1:0]   ras_ptr_r;      // next free slot; top entry is ras_ptr_r - 1
  logic [PW-1:0]   ras_ptr_dec_s;
  logic [CW-1:0]   ras_count_r;
  logic [CW-1:0]   ras_count_nxt_s;
  logic            ras_is_empty_s;
  logic            ras_is_full_s;
  logic [XLEN-1:0] ras_top_s;
  logic            ras_push_s;
  logic            ras_pop_s;
  logic            ras_replace_s;
  logic            ras_empty_r;
  logic            ras_full_r;

  assign ras_ptr_dec_s  = ras_ptr_r - PW'(1);
  assign ras_top_s      = ras_mem_r[ras_ptr_dec_s];
  assign ras_is_empty_s = (ras_count_r == {CW{1'b0}});
  assign ras_is_full_s  = (ras_count_r == DEPTH_C);

  // Sequential step size and the combinational next-sequential PC.
  always_comb begin
    if ((C_EXT != 0) && step_c) begin
      step_s = XLEN'(2);
    end else begin
      step_s = XLEN'(4);
    end
    pc_next_s = pc_r + step_s;
  end

  // Load detection, target selection and FSM / PC next-state.
  always_comb begin
    state_nxt_s    = state_r;
    pc_nxt_s       = pc_r;
    misalign_nxt_s = 1'b0;
    target_s       = redirect_pc;

    // Loads are ignored in BOOT so the reset vector is always fetched first.
    load_s = (state_r != BOOT) && (trap_en || redirect_en || ret_en);

    if (trap_en) begin
      target_s = trap_vec;
    end else if (ret_en && !ras_is_empty_s) begin
      target_s = ras_top_s;
    end else begin
      target_s = redirect_pc;
    end

    case (state_r)
      BOOT:    state_nxt_s = RUN;
      RUN:     state_nxt_s = load_s ? BUBBLE : RUN;
      BUBBLE:  state_nxt_s = RUN;
      default: state_nxt_s = BOOT;
    endcase

    if (load_s) begin
      pc_nxt_s       = target_s & ALIGN_MASK;
      misalign_nxt_s = is_misaligned(target_s);
    end else if ((state_r == RUN) && fetch_ready) begin
      pc_nxt_s = pc_next_s;
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // RAS operation decode; a trap overrides any call/return and leaves the stack alone.
  always_comb begin
    ras_push_s      = 1'b0;
    ras_pop_s       = 1'b0;
    ras_replace_s   = 1'b0;
    ras_count_nxt_s = ras_count_r;

    if (load_s && !trap_en) begin
      if (ret_en) begin
        if (call_en) begin
          // Pop and push together: swap the top entry, or plain push if empty.
          if (ras_is_empty_s) begin
            ras_push_s = 1'b1;
          end else begin
            ras_replace_s = 1'b1;
          end
        end else begin
          ras_pop_s = !ras_is_empty_s;
        end
      end else begin
        ras_push_s = redirect_en && call_en;
      end
    end else begin
      ras_push_s = 1'b0;
    end

    if (ras_push_s && !ras_is_full_s) begin
      ras_count_nxt_s = ras_count_r + CW'(1);
    end else if (ras_pop_s) begin
      ras_count_nxt_s = ras_count_r - CW'(1);
    end else begin
      ras_count_nxt_s = ras_count_r;
    end
  end

  // FSM state, fetch PC and registered handshake/pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= BOOT;
      pc_r          <= RESET_VEC;
      fetch_valid_r <= 1'b0;
      misalign_r    <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      pc_r          <= pc_nxt_s;
      fetch_valid_r <= (state_nxt_s == RUN);
      misalign_r    <= misalign_nxt_s;
    end
  end

  // Return address stack storage; a push when full overwrites the oldest slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_r[i] <= {XLEN{1'b0}};
      end
      ras_ptr_r   <= {PW{1'b0}};
      ras_count_r <= {CW{1'b0}};
      ras_empty_r <= 1'b1;
      ras_full_r  <= 1'b0;
    end else begin
      if (ras_push_s) begin
        ras_mem_r[ras_ptr_r] <= pc_next_s;
        ras_ptr_r            <= ras_ptr_r + PW'(1);
      end else if (ras_pop_s) begin
        ras_ptr_r <= ras_ptr_dec_s;
      end else if (ras_replace_s) begin
        ras_mem_r[ras_ptr_dec_s] <= pc_next_s;
      end else begin
        ras_ptr_r <= ras_ptr_r;
      end
      ras_count_r <= ras_count_nxt_s;
      ras_empty_r <= (ras_count_nxt_s == {CW{1'b0}});
      ras_full_r  <= (ras_count_nxt_s == DEPTH_C);
    end
  end

  assign fetch_valid = fetch_valid_r;
  assign fetch_pc    = pc_r;
  assign pc_next     = pc_next_s;
  assign ras_empty   = ras_empty_r;
  assign ras_full    = ras_full_r;
  assign misalign    = misalign_r;

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen : directed self-checking bench for pc_gen (default parameters)
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic [31:0] pc_next;
  logic        step_c;
  logic        trap_en;
  logic [31:0] trap_vec;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        call_en;
  logic        ret_en;
  logic        ras_empty;
  logic        ras_full;
  logic        misalign;

  int n_vec;
  int n_err;

  pc_gen dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_pc    (fetch_pc),
    .pc_next     (pc_next),
    .step_c      (step_c),
    .trap_en     (trap_en),
    .trap_vec    (trap_vec),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .call_en     (call_en),
    .ret_en      (ret_en),
    .ras_empty   (ras_empty),
    .ras_full    (ras_full),
    .misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: let the rising edge happen, then return at the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_loads();
    trap_en     = 1'b0;
    redirect_en = 1'b0;
    call_en     = 1'b0;
    ret_en      = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++; if (fetch_pc !== 32'h8000_0000) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", fetch_pc, 32'h8000_0000); end
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", fetch_valid); end
    n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", ras_empty); end
    n_vec++; if (ras_full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", ras_full); end
    n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
  endtask

  // Release reset with a redirect pending in BOOT: it must be ignored.
  task automatic test_boot_advance();
    fetch_ready = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0900;
    rst         = 1'b0;
    #1;
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL boot_valid got=%b exp=0", fetch_valid); end
    @(negedge clk);
    n_vec++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL run_valid got=%b exp=1", fetch_valid); end
    n_vec++; if (fetch_pc !== 32'h8000_0000) begin n_err++; $display("FAIL boot_ignores_load got=%h exp=%h", fetch_pc, 32'h8000_0000); end
    clear_loads();
    cyc();
    n_vec++; if (fetch_pc !== 32'h8000_0004) begin n_err++; $display("FAIL advance1 got=%h exp=%h", fetch_pc, 32'h8000_0004); end
    cyc();
    n_vec++; if (fetch_pc !== 32'h8000_0008) begin n_err++; $display("FAIL advance2 got=%h exp=%h", fetch_pc, 32'h8000_0008); end
  endtask

  // Back-pressure holds the request, then a compressed step.
  task automatic test_stall_step_c();
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_vec++; if (fetch_pc !== 32'h8000_0008) begin n_err++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, fetch_pc, 32'h8000_0008); end
      n_vec++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, fetch_valid); end
    end
    step_c = 1'b1;
    #1;
    n_vec++; if (pc_next !== 32'h8000_000A) begin n_err++; $display("FAIL pc_next_c got=%h exp=%h", pc_next, 32'h8000_000A); end
    fetch_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (fetch_pc !== 32'h8000_000A) begin n_err++; $display("FAIL step_c_pc got=%h exp=%h", fetch_pc, 32'h8000_000A); end
    step_c = 1'b0;
  endtask

  // Trap beats a simultaneous redirect and inserts one bubble.
  task automatic test_trap_priority();
    trap_en     = 1'b1;
    trap_vec    = 32'h0000_0100;
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0200;
    cyc();
    n_vec++; if (fetch_pc !== 32'h0000_0100) begin n_err++; $display("FAIL trap_pc got=%h exp=%h", fetch_pc, 32'h0000_0100); end
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL trap_bubble got=%b exp=0", fetch_valid); end
    clear_loads();
    cyc();
    n_vec++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL trap_resume got=%b exp=1", fetch_valid); end
    n_vec++; if (fetch_pc !== 32'h0000_0100) begin n_err++; $display("FAIL trap_resume_pc got=%h exp=%h", fetch_pc, 32'h0000_0100); end
    n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL trap_ras got=%b exp=1", ras_empty); end
  endtask

  // Call from 0x80000010 then return to 0x80000014.
  task automatic test_call_ret();
    redirect_en = 1'b1;
    redirect_pc = 32'h8000_0010;
    cyc();
    clear_loads();
    cyc();
    n_vec++; if (fetch_pc !== 32'h8000_0010) begin n_err++; $display("FAIL call_setup got=%h exp=%h", fetch_pc, 32'h8000_0010); end
    call_en     = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_4000;
    cyc();
    n_vec++; if (fetch_pc !== 32'h0000_4000) begin n_err++; $display("FAIL call_pc got=%h exp=%h", fetch_pc, 32'h0000_4000); end
    n_vec++; if (ras_empty !== 1'b0) begin n_err++; $display("FAIL call_nonempty got=%b exp=0", ras_empty); end
    clear_loads();
    cyc();
    ret_en      = 1'b1;
    redirect_pc = 32'h0000_0700;
    cyc();
    n_vec++; if (fetch_pc !== 32'h8000_0014) begin n_err++; $display("FAIL ret_pc got=%h exp=%h", fetch_pc, 32'h8000_0014); end
    n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL ret_empty got=%b exp=1", ras_empty); end
    clear_loads();
    cyc();
  endtask

  // Five calls overflow a 4-deep stack; returns pop LIFO, then fall back.
  task automatic test_ras_overflow();
    logic [31:0] ret_exp [5];
    ret_exp[0] = 32'h0000_4004;
    ret_exp[1] = 32'h0000_3004;
    ret_exp[2] = 32'h0000_2004;
    ret_exp[3] = 32'h0000_1004;
    ret_exp[4] = 32'h0000_0300;
    fetch_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      call_en     = 1'b1;
      redirect_en = 1'b1;
      redirect_pc = 32'h0000_1000 * (i + 1);
      cyc();
      n_vec++; if (fetch_pc !== 32'h0000_1000 * (i + 1)) begin n_err++; $display("FAIL call%0d_pc got=%h exp=%h", i, fetch_pc, 32'h0000_1000 * (i + 1)); end
      n_vec++; if (ras_full !== (i >= 3)) begin n_err++; $display("FAIL call%0d_full got=%b exp=%b", i, ras_full, (i >= 3)); end
      clear_loads();
      cyc();
    end
    redirect_pc = 32'h0000_0300;
    for (int k = 0; k < 5; k++) begin
      ret_en = 1'b1;
      cyc();
      n_vec++; if (fetch_pc !== ret_exp[k]) begin n_err++; $display("FAIL ret%0d_pc got=%h exp=%h", k, fetch_pc, ret_exp[k]); end
      n_vec++; if (ras_empty !== (k >= 3)) begin n_err++; $display("FAIL ret%0d_empty got=%b exp=%b", k, ras_empty, (k >= 3)); end
      n_vec++; if (ras_full !== 1'b0) begin n_err++; $display("FAIL ret%0d_full got=%b exp=0", k, ras_full); end
      clear_loads();
      cyc();
    end
  endtask

  // Address wrap and misaligned target.
  task automatic test_wrap_misalign();
    fetch_ready = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cyc();
    clear_loads();
    n_vec++; if (pc_next !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_pc_next got=%h exp=%h", pc_next, 32'h0000_0000); end
    cyc();
    n_vec++; if (fetch_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_start got=%h exp=%h", fetch_pc, 32'hFFFF_FFFC); end
    cyc();
    n_vec++; if (fetch_pc !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_pc got=%h exp=%h", fetch_pc, 32'h0000_0000); end
    n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL wrap_misalign got=%b exp=0", misalign); end
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0201;
    cyc();
    n_vec++; if (fetch_pc !== 32'h0000_0200) begin n_err++; $display("FAIL misalign_pc got=%h exp=%h", fetch_pc, 32'h0000_0200); end
    n_vec++; if (misalign !== 1'b1) begin n_err++; $display("FAIL misalign_pulse got=%b exp=1", misalign); end
    clear_loads();
    cyc();
    n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL misalign_clear got=%b exp=0", misalign); end
    n_vec++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL misalign_resume got=%b exp=1", fetch_valid); end
  endtask

  // Reset asserted during a bubble with a push and a new load pending.
  task automatic test_reset_mid_bubble();
    call_en     = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0500;
    cyc();
    n_vec++; if (ras_empty !== 1'b0) begin n_err++; $display("FAIL prerst_ras got=%b exp=0", ras_empty); end
    n_vec++; if (fetch_pc !== 32'h0000_0500) begin n_err++; $display("FAIL prerst_pc got=%h exp=%h", fetch_pc, 32'h0000_0500); end
    call_en     = 1'b0;
    redirect_pc = 32'h0000_0600;
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (fetch_pc !== 32'h8000_0000) begin n_err++; $display("FAIL rst_async_pc got=%h exp=%h", fetch_pc, 32'h8000_0000); end
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid got=%b exp=0", fetch_valid); end
    n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL rst_async_empty got=%b exp=1", ras_empty); end
    @(negedge clk);
    n_vec++; if (fetch_pc !== 32'h8000_0000) begin n_err++; $display("FAIL rst_hold_pc got=%h exp=%h", fetch_pc, 32'h8000_0000); end
    clear_loads();
    rst = 1'b0;
    cyc();
    n_vec++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL rerun_valid got=%b exp=1", fetch_valid); end
    n_vec++; if (fetch_pc !== 32'h8000_0000) begin n_err++; $display("FAIL rerun_pc got=%h exp=%h", fetch_pc, 32'h8000_0000); end
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b1;
    fetch_ready = 1'b0;
    step_c      = 1'b0;
    trap_vec    = 32'h0000_0000;
    redirect_pc = 32'h0000_0000;
    clear_loads();
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_boot_advance();
    test_stall_step_c();
    test_trap_priority();
    test_call_ret();
    test_ras_overflow();
    test_wrap_misalign();
    test_reset_mid_bubble();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
